bcd_display_scheduler: RTL and testbench

BCD_DISPLAY_SCHEDULER -- requirements
Module: bcd_display_scheduler

---
 rtl/display_pkg.sv | 18 +
 rtl/bcd_add3.sv | 10 +
 rtl/bcd_display_scheduler.sv | 102 ++++++++++
 tb/tb_bcd_display_scheduler.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the BCD display scheduler: FSM states, digit count,
// largest displayable value and the decoder mode codes.
package display_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      PUBLISH = 2'd2
   } state_t;

   localparam int unsigned MAX_VALUE = 99999;
   localparam int          DIGITS    = 5;

   localparam logic [1:0] SHOW  = 2'b00;
   localparam logic [1:0] BLANK = 2'b01;
   localparam logic [1:0] CONV  = 2'b10;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble correction for one BCD digit: values of 5 or more get +3
// so that the following left shift carries cleanly into the next digit.
module bcd_add3 (
   input  logic [3:0] digit,
   output logic [3:0] fixed
);

   assign fixed = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bcd_display_scheduler.sv
// Converts a binary value to five BCD digits with a serial double-dabble
// (one bit per cycle) and publishes them to a 7-segment decoder.
module bcd_display_scheduler
   import display_pkg::*;
#(
   parameter int WIDTH = 17
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] valor,
   input  logic             blank,
   output logic             busy,
   output logic             done,
   output logic [3:0]       entrada1,
   output logic [3:0]       entrada2,
   output logic [3:0]       entrada3,
   output logic [3:0]       entrada4,
   output logic [3:0]       entrada5,
   output logic             overflow,
   output logic [1:0]       controle_displays,
   output state_t           state
);

   logic [WIDTH-1:0]    val_sr;
   logic [4*DIGITS-1:0] scratch;
   logic [4*DIGITS-1:0] corrected;
   logic [4:0]          cnt;
   logic                ovf_cap;
   logic                busy_next;

   for (genvar g = 0; g < DIGITS; g++) begin : g_add3
      bcd_add3 u_add3 (
         .digit (scratch[4*g +: 4]),
         .fixed (corrected[4*g +: 4])
      );
   end

   // Busy as it will be after this edge, so the mode code lines up with busy.
   always_comb begin
      busy_next = 1'b0;
      case (state)
         IDLE:    busy_next = start;
         SHIFT:   busy_next = 1'b1;
         default: busy_next = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state             <= IDLE;
         busy              <= 1'b0;
         done              <= 1'b0;
         entrada1          <= 4'd0;
         entrada2          <= 4'd0;
         entrada3          <= 4'd0;
         entrada4          <= 4'd0;
         entrada5          <= 4'd0;
         overflow          <= 1'b0;
         controle_displays <= SHOW;
         val_sr            <= '0;
         scratch           <= '0;
         cnt               <= 5'd0;
         ovf_cap           <= 1'b0;
      end else begin
         done              <= 1'b0;
         busy              <= busy_next;
         controle_displays <= blank ? BLANK : (busy_next ? CONV : SHOW);
         case (state)
            IDLE: begin
               if (start) begin
                  val_sr  <= valor;
                  ovf_cap <= (32'(valor) > MAX_VALUE);
                  scratch <= '0;
                  cnt     <= 5'd0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               // A carry out of the top digit can only come from an out-of-range value.
               scratch <= {corrected[4*DIGITS-2:0], val_sr[WIDTH-1]};
               ovf_cap <= ovf_cap | corrected[4*DIGITS-1];
               val_sr  <= {val_sr[WIDTH-2:0], 1'b0};
               cnt     <= cnt + 5'd1;
               if (cnt == 5'(WIDTH - 1)) state <= PUBLISH;
            end
            PUBLISH: begin
               overflow <= ovf_cap;
               entrada1 <= ovf_cap ? 4'd0 : scratch[3:0];
               entrada2 <= ovf_cap ? 4'd0 : scratch[7:4];
               entrada3 <= ovf_cap ? 4'd0 : scratch[11:8];
               entrada4 <= ovf_cap ? 4'd0 : scratch[15:12];
               entrada5 <= ovf_cap ? 4'd0 : scratch[19:16];
               done     <= 1'b1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_display_scheduler.sv
// Directed bench for bcd_display_scheduler: expected digits are queued when a
// conversion is issued and checked by a monitor whenever done is seen.
module tb_bcd_display_scheduler;
   import display_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [16:0] valor = '0;
   logic        blank = 1'b0;
   logic        busy, done, overflow;
   logic [3:0]  entrada1, entrada2, entrada3, entrada4, entrada5;
   logic [1:0]  controle_displays;
   state_t      state;

   logic [20:0] exp_q[$];
   logic [20:0] last_pub = '0;
   int          checks = 0;
   int          errors = 0;

   bcd_display_scheduler #(.WIDTH(17)) dut (
      .clock             (clock),
      .reset             (reset),
      .start             (start),
      .valor             (valor),
      .blank             (blank),
      .busy              (busy),
      .done              (done),
      .entrada1          (entrada1),
      .entrada2          (entrada2),
      .entrada3          (entrada3),
      .entrada4          (entrada4),
      .entrada5          (entrada5),
      .overflow          (overflow),
      .controle_displays (controle_displays),
      .state             (state)
   );

   always #5 clock = ~clock;

   function automatic logic [20:0] shown();
      return {overflow, entrada5, entrada4, entrada3, entrada2, entrada1};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Monitor: every done pulse must match the oldest queued expectation.
   always @(negedge clock) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done got=%0h exp=none at %0t", shown(), $time);
         end else begin
            chk("publish", 32'(shown()), 32'(exp_q.pop_front()));
         end
      end
   end

   // Issues one conversion and checks timing, held outputs and display mode.
   task automatic run_conv(input logic [16:0] v, input logic [20:0] exp,
                           input int repulse_at, input int blank_until);
      logic bl;
      bl    = (blank_until > 0);
      start = 1'b1;
      valor = v;
      blank = bl;
      exp_q.push_back(exp);
      @(posedge clock); #1;
      start = 1'b0;
      valor = 17'($urandom_range(0, 131071));
      chk("accept_busy", 32'(busy), 32'd1);
      chk("accept_done", 32'(done), 32'd0);
      chk("accept_ctrl", 32'(controle_displays), bl ? 32'd1 : 32'd2);
      for (int i = 1; i <= 17; i++) begin
         bl    = (i < blank_until);
         blank = bl;
         if (i == repulse_at) begin
            start = 1'b1;
            valor = 17'd500;
         end
         @(posedge clock); #1;
         start = 1'b0;
         valor = 17'($urandom_range(0, 131071));
         chk("shift_busy", 32'(busy), 32'd1);
         chk("shift_done", 32'(done), 32'd0);
         chk("shift_hold", 32'(shown()), 32'(last_pub));
         chk("shift_ctrl", 32'(controle_displays), bl ? 32'd1 : 32'd2);
      end
      bl    = (18 < blank_until);
      blank = bl;
      @(posedge clock); #1;
      chk("pub_done", 32'(done), 32'd1);
      chk("pub_busy", 32'(busy), 32'd0);
      chk("pub_ctrl", 32'(controle_displays), bl ? 32'd1 : 32'd0);
      last_pub = exp;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_digits", 32'(shown()), 32'd0);
      chk("rst_ctrl", 32'(controle_displays), 32'd0);
      chk("rst_state", 32'(state), 32'(IDLE));
      reset = 1'b0;
      @(posedge clock); #1;
      chk("idle_busy", 32'(busy), 32'd0);

      run_conv(17'd12345,  21'h012345, 0, 0);
      run_conv(17'd99999,  21'h099999, 0, 0);
      run_conv(17'd100000, 21'h100000, 0, 0);
      run_conv(17'd0,      21'h000000, 0, 0);
      run_conv(17'd131071, 21'h100000, 0, 0);
      // Start re-pulsed mid-conversion is ignored; back-to-back start is accepted.
      run_conv(17'd7,      21'h000007, 5, 0);
      run_conv(17'd500,    21'h000500, 0, 0);
      run_conv(17'd4096,   21'h004096, 0, 10);
      run_conv(17'd65535,  21'h065535, 0, 99);
      blank = 1'b0;
      @(posedge clock); #1;
      chk("unblank_ctrl", 32'(controle_displays), 32'd0);

      // Abort a conversion with reset during SHIFT; reset also beats start.
      start = 1'b1;
      valor = 17'd4321;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (8) @(posedge clock);
      #1;
      chk("abort_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      start = 1'b1;
      blank = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      start = 1'b0;
      blank = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_digits", 32'(shown()), 32'd0);
      chk("abort_ctrl", 32'(controle_displays), 32'd0);
      chk("abort_state", 32'(state), 32'(IDLE));
      last_pub = '0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clock); #1;
         chk("abort_no_done", 32'(done), 32'd0);
      end
      chk("abort_hold", 32'(shown()), 32'd0);

      run_conv(17'd805, 21'h000805, 0, 0);
      repeat (3) @(posedge clock);
      #1;
      chk("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
